// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data port of the on-chip RAM between the CPU data side
// (primary master, C side) and a secondary master such as a debug loader or
// DMA engine (S side). The RAM has a one-cycle read latency.
//
// The CPU has fixed priority. Two mechanisms stop the S side from being
// locked out:
//   * a starvation guard forces one S grant after MAX_WAIT denied cycles;
//   * a lock mode lets S run back-to-back read-modify-write sequences for
//     at most MAX_LOCK cycles before the CPU gets the port back.
// CPU stall cycles are counted in a saturating 32-bit counter.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   c_req_i .. c_wd_i    CPU request, write enable, byte enables, addr, data
//   c_stall_o            CPU request not granted this cycle
//   c_rvalid_o, c_rd_o   CPU read return (cycle after a granted CPU read)
//   s_req_i .. s_wd_i    secondary request, lock, write enable, be, addr, data
//   s_gnt_o              secondary access accepted this cycle
//   s_rvalid_o, s_rd_o   secondary read return
//   m_addr_o .. m_wd_o   RAM address, write enable, byte enables, write data
//   m_rd_i               RAM read data (one cycle after the address)
//   stall_cnt_o          saturating count of cycles with c_stall_o high
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int RAM_DEPTH = 14,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_LOCK  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 c_req_i,
    input  logic                 c_we_i,
    input  logic [3:0]           c_be_i,
    input  logic [RAM_DEPTH-1:0] c_addr_i,
    input  logic [31:0]          c_wd_i,
    output logic                 c_stall_o,
    output logic                 c_rvalid_o,
    output logic [31:0]          c_rd_o,

    input  logic                 s_req_i,
    input  logic                 s_lock_i,
    input  logic                 s_we_i,
    input  logic [3:0]           s_be_i,
    input  logic [RAM_DEPTH-1:0] s_addr_i,
    input  logic [31:0]          s_wd_i,
    output logic                 s_gnt_o,
    output logic                 s_rvalid_o,
    output logic [31:0]          s_rd_o,

    output logic [RAM_DEPTH-1:0] m_addr_o,
    output logic                 m_we_o,
    output logic [3:0]           m_be_o,
    output logic [31:0]          m_wd_o,
    input  logic [31:0]          m_rd_i,

    output logic [31:0]          stall_cnt_o
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    typedef enum logic {
        NORMAL,
        LOCKED
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  lock_q, lock_d;
    logic        rd_c_q, rd_c_d;
    logic        rd_s_q, rd_s_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        c_gnt;
    logic        s_gnt;
    logic        c_stall;
    logic        starve;

    // State register. Reset drops any lock in progress immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A lock is taken by any S grant that carries s_lock_i,
    // including a starvation grant. It is released when S stops asking, stops
    // asking for the lock, or has held the port for MAX_LOCK locked cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL: begin
                if (s_gnt && s_lock_i) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if ((s_gnt && !s_lock_i) || !s_req_i || (lock_q == LOCK_MAX)) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Grant logic. In NORMAL the CPU wins unless S has been denied MAX_WAIT
    // cycles in a row; in LOCKED S owns the port and the CPU always waits.
    always_comb begin
        starve  = 1'b0;
        c_gnt   = 1'b0;
        s_gnt   = 1'b0;
        c_stall = 1'b0;
        unique case (state_q)
            NORMAL: begin
                starve  = s_req_i && (wait_q == WAIT_MAX);
                s_gnt   = starve || (s_req_i && !c_req_i);
                c_gnt   = c_req_i && !starve;
                c_stall = c_req_i && starve;
            end
            LOCKED: begin
                s_gnt   = s_req_i;
                c_stall = c_req_i;
            end
            default: ;
        endcase
    end

    // Counter and read-flag next values. wait_d counts consecutive denied S
    // cycles; lock_d counts locked cycles starting from 1 on lock entry, so
    // the forced exit happens after exactly MAX_LOCK locked cycles.
    always_comb begin
        if (s_gnt || !s_req_i) begin
            wait_d = 4'd0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end

        lock_d = 8'd0;
        if (state_q == NORMAL) begin
            if (s_gnt && s_lock_i) begin
                lock_d = 8'd1;
            end
        end else if (state_d == LOCKED) begin
            lock_d = lock_q + 8'd1;
        end

        rd_c_d = c_gnt && !c_we_i;
        rd_s_d = s_gnt && !s_we_i;

        stall_cnt_d = stall_cnt_q;
        if (c_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counters and read-return flags. Clearing rd_c/rd_s on reset is what
    // throws away a read that was in flight when reset hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q      <= 4'd0;
            lock_q      <= 8'd0;
            rd_c_q      <= 1'b0;
            rd_s_q      <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            wait_q      <= wait_d;
            lock_q      <= lock_d;
            rd_c_q      <= rd_c_d;
            rd_s_q      <= rd_s_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Port mux. With no grant the address/data follow the CPU side so the
    // RAM inputs do not toggle needlessly; only M_WE must be quiet. The
    // handshake outputs are gated by reset so they drop without a clock.
    always_comb begin
        m_addr_o = s_gnt ? s_addr_i : c_addr_i;
        m_be_o   = s_gnt ? s_be_i   : c_be_i;
        m_wd_o   = s_gnt ? s_wd_i   : c_wd_i;
        m_we_o   = rst_ni && ((c_gnt && c_we_i) || (s_gnt && s_we_i));

        c_stall_o = rst_ni && c_stall;
        s_gnt_o   = rst_ni && s_gnt;

        c_rvalid_o = rd_c_q;
        s_rvalid_o = rd_s_q;
        c_rd_o     = rd_c_q ? m_rd_i : 32'd0;
        s_rd_o     = rd_s_q ? m_rd_i : 32'd0;

        stall_cnt_o = stall_cnt_q;
    end

endmodule
